fp_div_param: RTL and testbench

//   Parametrised IEEE-754 binary floating-point divider, z = a / b, multi-cycle, bit-serial.

---
 rtl/fp_div_param.sv | 204 ++++++++++++++++++++
 tb/tb_fp_div_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_param.sv
// Parametrised IEEE-754 divider z = a / b: stb/ack operand and result handshakes,
// bit-serial restoring division, round-to-nearest-even, flush-to-zero, IEEE flags.
module fp_div_param #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+FRAC_W:0]     input_a,
    input  logic                      input_a_stb,
    output logic                      input_a_ack,
    input  logic [EXP_W+FRAC_W:0]     input_b,
    input  logic                      input_b_stb,
    output logic                      input_b_ack,
    output logic [EXP_W+FRAC_W:0]     output_z,
    output logic                      output_z_stb,
    input  logic                      output_z_ack,
    output logic [4:0]                output_flags
);

    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int M_W  = FRAC_W + 1;
    localparam int Q_W  = FRAC_W + 4;
    localparam int E_W  = EXP_W + 2;
    localparam int C_W  = $clog2(Q_W);
    localparam int BIAS = 2**(EXP_W-1) - 1;

    localparam logic signed [E_W-1:0] BIAS_E   = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_SAT    = E_W'(2**EXP_W - 1);
    localparam logic signed [E_W-1:0] E_ZERO   = '0;
    localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [C_W-1:0]        CNT_LAST = C_W'(Q_W - 1);
    localparam logic [C_W-1:0]        CNT_ONE  = C_W'(1);

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, DIVIDE, NORM, ROUND, PACK, PUT_Z
    } state_t;

    state_t                 state;
    logic [W-1:0]           a_reg, b_reg;
    logic                   sa, sb, z_sign;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [EXP_W-1:0]       ea, eb;
    logic [M_W-1:0]         ma, mb;
    logic signed [E_W-1:0]  e;
    logic [Q_W-1:0]         q;
    logic [M_W:0]           rem;
    logic [C_W-1:0]         cnt;
    logic                   sticky, inexact;
    logic [FRAC_W-1:0]      frac;

    logic [EXP_W-1:0]       a_exp, b_exp;
    logic [FRAC_W-1:0]      a_frac, b_frac;
    assign a_exp  = a_reg[W-2 -: EXP_W];
    assign b_exp  = b_reg[W-2 -: EXP_W];
    assign a_frac = a_reg[FRAC_W-1:0];
    assign b_frac = b_reg[FRAC_W-1:0];

    // One restoring-division step: trial-subtract the divisor from the partial remainder.
    logic          rem_ge;
    logic [M_W:0]  rem_sub;
    always_comb begin
        rem_ge  = rem >= {1'b0, mb};
        rem_sub = rem - {1'b0, mb};
    end

    // Normalised quotient layout: [Q_W-1:3] mantissa, [2] guard, [1] round, [0] folds into sticky.
    logic [M_W-1:0] mant_in;
    logic           g_bit, r_bit, s_bit, inc;
    logic [M_W:0]   mant_sum;
    always_comb begin
        mant_in  = q[Q_W-1:3];
        g_bit    = q[2];
        r_bit    = q[1];
        s_bit    = sticky | q[0];
        inc      = g_bit & (r_bit | s_bit | mant_in[0]);
        mant_sum = {1'b0, mant_in} + {{M_W{1'b0}}, inc};
    end

    // NOTE: only control state and outputs are reset; datapath registers are always
    // loaded before use, so leaving them unreset saves reset fan-out.
    // NOTE: every register in this block is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            output_flags <= '0;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a_reg       <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= GET_B;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b_reg       <= input_b;
                        input_b_ack <= 1'b0;
                        state       <= UNPACK;
                    end
                end
                UNPACK: begin
                    sa     <= a_reg[W-1];
                    sb     <= b_reg[W-1];
                    ea     <= a_exp;
                    eb     <= b_exp;
                    ma     <= {1'b1, a_frac};
                    mb     <= {1'b1, b_frac};
                    a_zero <= a_exp == '0;
                    b_zero <= b_exp == '0;
                    a_inf  <= (a_exp == EXP_ONES) && (a_frac == '0);
                    b_inf  <= (b_exp == EXP_ONES) && (b_frac == '0);
                    a_nan  <= (a_exp == EXP_ONES) && (a_frac != '0);
                    b_nan  <= (b_exp == EXP_ONES) && (b_frac != '0);
                    a_snan <= (a_exp == EXP_ONES) && (a_frac != '0) && !a_frac[FRAC_W-1];
                    b_snan <= (b_exp == EXP_ONES) && (b_frac != '0) && !b_frac[FRAC_W-1];
                    state  <= SPECIAL;
                end
                SPECIAL: begin
                    z_sign <= sa ^ sb;
                    state  <= PUT_Z;
                    if (a_nan || b_nan) begin
                        output_z     <= QNAN;
                        output_flags <= {a_snan | b_snan, 4'b0000};
                    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        output_z     <= QNAN;
                        output_flags <= 5'b10000;
                    end else if (b_zero && !a_inf) begin
                        output_z     <= {sa ^ sb, EXP_ONES, {FRAC_W{1'b0}}};
                        output_flags <= 5'b01000;
                    end else if (a_inf) begin
                        output_z     <= {sa ^ sb, EXP_ONES, {FRAC_W{1'b0}}};
                        output_flags <= 5'b00000;
                    end else if (b_inf || a_zero) begin
                        output_z     <= {sa ^ sb, {(W-1){1'b0}}};
                        output_flags <= 5'b00000;
                    end else begin
                        e     <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
                        rem   <= {1'b0, ma};
                        q     <= '0;
                        cnt   <= CNT_LAST;
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    q   <= {q[Q_W-2:0], rem_ge};
                    rem <= rem_ge ? {rem_sub[M_W-1:0], 1'b0} : {rem[M_W-1:0], 1'b0};
                    cnt <= cnt - CNT_ONE;
                    if (cnt == '0)
                        state <= NORM;
                end
                NORM: begin
                    sticky <= rem != '0;
                    if (!q[Q_W-1]) begin
                        q <= {q[Q_W-2:0], 1'b0};
                        e <= e - E_ONE;
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    inexact <= g_bit | r_bit | s_bit;
                    if (mant_sum[M_W]) begin
                        frac <= mant_sum[FRAC_W:1];
                        e    <= e + E_ONE;
                    end else begin
                        frac <= mant_sum[FRAC_W-1:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    if (e >= E_SAT) begin
                        output_z     <= {z_sign, EXP_ONES, {FRAC_W{1'b0}}};
                        output_flags <= 5'b00101;
                    end else if (e <= E_ZERO) begin
                        output_z     <= {z_sign, {(W-1){1'b0}}};
                        output_flags <= 5'b00011;
                    end else begin
                        output_z     <= {z_sign, e[EXP_W-1:0], frac};
                        output_flags <= {4'b0000, inexact};
                    end
                    state <= PUT_Z;
                end
                PUT_Z: begin
                    output_z_stb <= 1'b1;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_param.sv
// Directed-vector bench for fp_div_param: single-precision vector table, handshake
// corner sequences (backpressure, late strobes, mid-divide reset) and a double-precision instance.
module tb_fp_div_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] s_a, s_b, s_z;
    logic        s_a_stb, s_a_ack, s_b_stb, s_b_ack, s_z_stb, s_z_ack;
    logic [4:0]  s_flags;

    logic [63:0] d_a, d_b, d_z;
    logic        d_a_stb, d_a_ack, d_b_stb, d_b_ack, d_z_stb, d_z_ack;
    logic [4:0]  d_flags;

    fp_div_param dut_sp (
        .clk          (clk),
        .rst          (rst),
        .input_a      (s_a),
        .input_a_stb  (s_a_stb),
        .input_a_ack  (s_a_ack),
        .input_b      (s_b),
        .input_b_stb  (s_b_stb),
        .input_b_ack  (s_b_ack),
        .output_z     (s_z),
        .output_z_stb (s_z_stb),
        .output_z_ack (s_z_ack),
        .output_flags (s_flags)
    );

    fp_div_param #(.EXP_W(11), .FRAC_W(52)) dut_dp (
        .clk          (clk),
        .rst          (rst),
        .input_a      (d_a),
        .input_a_stb  (d_a_stb),
        .input_a_ack  (d_a_ack),
        .input_b      (d_b),
        .input_b_stb  (d_b_stb),
        .input_b_ack  (d_b_ack),
        .output_z     (d_z),
        .output_z_stb (d_z_stb),
        .output_z_ack (d_z_ack),
        .output_flags (d_flags)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // which: 0 = a_ack, 1 = b_ack, 2 = z_stb
    function automatic logic sig(input bit dp, input int which);
        case (which)
            0:       return dp ? d_a_ack : s_a_ack;
            1:       return dp ? d_b_ack : s_b_ack;
            default: return dp ? d_z_stb : s_z_stb;
        endcase
    endfunction

    task automatic wait_sig(input bit dp, input int which, input int budget,
                            input string name, output int cycles);
        cycles = 0;
        while (!sig(dp, which) && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({name, " ready"}, 64'(sig(dp, which)), 64'd1);
    endtask

    task automatic send_ab(input bit dp, input logic [63:0] a, input logic [63:0] b,
                           input int delay, input string name);
        int c;
        wait_sig(dp, 0, 50, {name, " a_ack"}, c);
        repeat (delay) begin @(posedge clk); #1; end
        if (dp) begin d_a = a; d_a_stb = 1'b1; end
        else    begin s_a = a[31:0]; s_a_stb = 1'b1; end
        @(posedge clk); #1;
        s_a_stb = 1'b0; d_a_stb = 1'b0;
        wait_sig(dp, 1, 50, {name, " b_ack"}, c);
        repeat (delay) begin @(posedge clk); #1; end
        if (dp) begin d_b = b; d_b_stb = 1'b1; end
        else    begin s_b = b[31:0]; s_b_stb = 1'b1; end
        @(posedge clk); #1;
        s_b_stb = 1'b0; d_b_stb = 1'b0;
    endtask

    // Called right after the b transfer edge; lat < 0 skips the latency check.
    task automatic get_z(input bit dp, input logic [63:0] z_exp, input logic [4:0] f_exp,
                         input int lat, input int hold, input string name);
        int          c;
        logic [63:0] z;
        logic [4:0]  f;
        logic        stable;
        wait_sig(dp, 2, 200, {name, " z_stb"}, c);
        if (lat >= 0) check({name, " latency"}, 64'(c), 64'(lat));
        z = dp ? d_z : {32'h0, s_z};
        f = dp ? d_flags : s_flags;
        check({name, " z"}, z, z_exp);
        check({name, " flags"}, 64'(f), 64'(f_exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            stable = ((dp ? d_z : {32'h0, s_z}) == z) && ((dp ? d_flags : s_flags) == f)
                     && sig(dp, 2) && !sig(dp, 0);
            check($sformatf("%s hold%0d", name, i), 64'(stable), 64'd1);
        end
        if (dp) d_z_ack = 1'b1; else s_z_ack = 1'b1;
        @(posedge clk); #1;
        s_z_ack = 1'b0; d_z_ack = 1'b0;
        check({name, " z_stb drop"}, 64'(sig(dp, 2)), 64'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h41C80000, 32'h40000000, 32'h41480000, 5'b00000, 33}; // 25/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 33}; // 1/3
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 3};  // 1/0
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 3};  // 0/0
        vecs[4]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 33}; // overflow
        vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 33}; // underflow
        vecs[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 3};  // sNaN a
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 3};  // qNaN a
        vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 3};  // inf/inf
        vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 3};  // -inf/2
        vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 3};  // 1/-inf
        vecs[11] = '{32'h80000000, 32'h40400000, 32'h80000000, 5'b00000, 3};  // -0/3
        vecs[12] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 3};  // -1/0
        vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 3};  // denormal a
        vecs[14] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 5'b01000, 3};  // denormal b
        vecs[15] = '{32'hC0C00000, 32'h40400000, 32'hC0000000, 5'b00000, 33}; // -6/3
        vecs[16] = '{32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 5'b00001, 33}; // 1/10
        vecs[17] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 3};  // inf/0
        vecs[18] = '{32'h3F800000, 32'hFF800001, 32'h7FC00000, 5'b10000, 3};  // sNaN b

        rst = 1'b1;
        s_a = '0; s_b = '0; s_a_stb = 1'b0; s_b_stb = 1'b0; s_z_ack = 1'b0;
        d_a = '0; d_b = '0; d_a_stb = 1'b0; d_b_stb = 1'b0; d_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset a_ack", 64'(s_a_ack), 64'd0);
        check("reset b_ack", 64'(s_b_ack), 64'd0);
        check("reset z_stb", 64'(s_z_stb), 64'd0);
        check("reset z",     64'(s_z),     64'd0);
        check("reset flags", 64'(s_flags), 64'd0);
        @(posedge clk); #1;
        check("a_ack after reset", 64'(s_a_ack), 64'd1);

        for (int i = 0; i < 19; i++) begin
            send_ab(1'b0, 64'(vecs[i].a), 64'(vecs[i].b), 0, $sformatf("vec%0d", i));
            get_z(1'b0, 64'(vecs[i].z), vecs[i].flags, vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // Result held under backpressure.
        send_ab(1'b0, 64'h41C80000, 64'h40000000, 0, "bp");
        get_z(1'b0, 64'h41480000, 5'b00000, 33, 5, "bp");
        check("bp a_ack low after transfer", 64'(s_a_ack), 64'd0);

        // Late operand strobes.
        send_ab(1'b0, 64'h41C80000, 64'h40000000, 3, "dly");
        get_z(1'b0, 64'h41480000, 5'b00000, 33, 0, "dly");

        // One-cycle reset in the middle of DIVIDE.
        send_ab(1'b0, 64'h3F800000, 64'h40400000, 0, "rst_mid");
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid a_ack", 64'(s_a_ack), 64'd0);
        check("rst_mid b_ack", 64'(s_b_ack), 64'd0);
        check("rst_mid z_stb", 64'(s_z_stb), 64'd0);
        check("rst_mid z",     64'(s_z),     64'd0);
        check("rst_mid flags", 64'(s_flags), 64'd0);
        send_ab(1'b0, 64'h41C80000, 64'h40000000, 0, "post_rst");
        get_z(1'b0, 64'h41480000, 5'b00000, 33, 0, "post_rst");

        // Double-precision instance.
        send_ab(1'b1, 64'h4039000000000000, 64'h4000000000000000, 0, "dp 25/2");
        get_z(1'b1, 64'h4029000000000000, 5'b00000, 62, 0, "dp 25/2");
        send_ab(1'b1, 64'h3FF0000000000000, 64'h4008000000000000, 0, "dp 1/3");
        get_z(1'b1, 64'h3FD5555555555555, 5'b00001, 62, 0, "dp 1/3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
